// File: rtl/warp_issue_scheduler.sv
// Round-robin issue scheduler: picks one eligible warp per cycle, pops its FIFO
// and registers the instruction into a valid/ready output stage.
module warp_issue_scheduler #(
    parameter int NUM_WARPS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int WID_W      = $clog2(NUM_WARPS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic                            flush,
    input  logic [NUM_WARPS-1:0]            fifo_valid,
    input  logic [NUM_WARPS*DATA_WIDTH-1:0] fifo_data,
    output logic [NUM_WARPS-1:0]            fifo_pop,
    input  logic [NUM_WARPS-1:0]            warp_stall,
    output logic                            issue_valid,
    input  logic                            issue_ready,
    output logic [DATA_WIDTH-1:0]           issue_instr,
    output logic [WID_W-1:0]                issue_warp_id,
    output logic [31:0]                     issue_count,
    output logic                            idle
);

    localparam logic [WID_W:0]   NUM_W_EXT = (WID_W+1)'(NUM_WARPS);
    localparam logic [WID_W-1:0] LAST_WID  = WID_W'(NUM_WARPS - 1);

    // Returns {found, warp_id} of the first eligible warp scanning from ptr upwards with wrap.
    function automatic logic [WID_W:0] rr_pick(input logic [NUM_WARPS-1:0] elig,
                                               input logic [WID_W-1:0]     ptr);
        logic [WID_W:0] idx;
        logic [WID_W:0] pick;
        pick = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = {1'b0, ptr} + (WID_W+1)'(i);
            if (idx >= NUM_W_EXT) begin
                idx = idx - NUM_W_EXT;
            end else begin
                idx = idx;
            end
            if (!pick[WID_W] && elig[idx[WID_W-1:0]]) begin
                pick = {1'b1, idx[WID_W-1:0]};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    logic [DATA_WIDTH-1:0] head_data_s [NUM_WARPS];
    logic [NUM_WARPS-1:0]  eligible_s;
    logic                  accept_s;
    logic                  load_en_s;
    logic                  do_load_s;
    logic [WID_W:0]        pick_s;
    logic [WID_W-1:0]      grant_s;
    logic [WID_W-1:0]      next_ptr_s;

    logic                  issue_valid_r;
    logic [DATA_WIDTH-1:0] issue_instr_r;
    logic [WID_W-1:0]      issue_warp_id_r;
    logic [31:0]           issue_count_r;
    logic [WID_W-1:0]      rr_ptr_r;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_head
        assign head_data_s[w] = fifo_data[w*DATA_WIDTH +: DATA_WIDTH];
    end

    // Eligibility, handshake and round-robin grant selection.
    always_comb begin
        eligible_s = fifo_valid & ~warp_stall;
        accept_s   = issue_valid_r & issue_ready;
        load_en_s  = enable & ~flush & (~issue_valid_r | issue_ready);
        pick_s     = rr_pick(eligible_s, rr_ptr_r);
        grant_s    = pick_s[WID_W-1:0];
        // rst_n gating keeps pops quiet while the block is held in reset.
        do_load_s  = load_en_s & pick_s[WID_W] & rst_n;
        if (grant_s == LAST_WID) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_s + WID_W'(1);
        end
    end

    // One-hot pop strobe for the granted warp.
    always_comb begin
        fifo_pop = '0;
        if (do_load_s) begin
            fifo_pop[grant_s] = 1'b1;
        end else begin
            fifo_pop = '0;
        end
    end

    // Output stage, round-robin pointer and accepted-issue counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid_r   <= 1'b0;
            issue_instr_r   <= '0;
            issue_warp_id_r <= '0;
            issue_count_r   <= 32'd0;
            rr_ptr_r        <= '0;
        end else begin
            if (do_load_s) begin
                issue_valid_r   <= 1'b1;
                issue_instr_r   <= head_data_s[grant_s];
                issue_warp_id_r <= grant_s;
                rr_ptr_r        <= next_ptr_s;
            end else if (accept_s || flush) begin
                issue_valid_r   <= 1'b0;
            end else begin
                issue_valid_r   <= issue_valid_r;
            end
            // A handshake completing alongside a flush still counts.
            if (accept_s) begin
                issue_count_r <= issue_count_r + 32'd1;
            end else begin
                issue_count_r <= issue_count_r;
            end
        end
    end

    assign issue_valid   = issue_valid_r;
    assign issue_instr   = issue_instr_r;
    assign issue_warp_id = issue_warp_id_r;
    assign issue_count   = issue_count_r;
    assign idle          = ~issue_valid_r & (fifo_valid == '0);

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Directed bench for warp_issue_scheduler: a per-cycle vector table followed by
// round-robin, backpressure, stall and mid-burst reset sequences.
module tb_warp_issue_scheduler;

    typedef struct {
        logic         en;
        logic         fl;
        logic [3:0]   fv;
        logic [3:0]   stall;
        logic         rdy;
        logic [127:0] data;
        logic [3:0]   pop;
        logic         idle_e;
        logic         iv;
        logic [31:0]  instr;
        logic [1:0]   wid;
        logic [31:0]  cnt;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         flush;
    logic [3:0]   fifo_valid;
    logic [127:0] fifo_data;
    logic [3:0]   fifo_pop;
    logic [3:0]   warp_stall;
    logic         issue_valid;
    logic         issue_ready;
    logic [31:0]  issue_instr;
    logic [1:0]   issue_warp_id;
    logic [31:0]  issue_count;
    logic         idle;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    warp_issue_scheduler #(.NUM_WARPS(4), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .flush        (flush),
        .fifo_valid   (fifo_valid),
        .fifo_data    (fifo_data),
        .fifo_pop     (fifo_pop),
        .warp_stall   (warp_stall),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_instr  (issue_instr),
        .issue_warp_id(issue_warp_id),
        .issue_count  (issue_count),
        .idle         (idle)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic fl, input logic [3:0] fv,
                                input logic [3:0] stall, input logic rdy, input logic [127:0] data,
                                input logic [3:0] pop, input logic idle_e, input logic iv,
                                input logic [31:0] instr, input logic [1:0] wid, input logic [31:0] cnt);
        vec_t v;
        v.en = en; v.fl = fl; v.fv = fv; v.stall = stall; v.rdy = rdy; v.data = data;
        v.pop = pop; v.idle_e = idle_e; v.iv = iv; v.instr = instr; v.wid = wid; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive(input logic en, input logic fl, input logic [3:0] fv,
                         input logic [3:0] stall, input logic rdy, input logic [127:0] data);
        enable = en; flush = fl; fifo_valid = fv; warp_stall = stall;
        issue_ready = rdy; fifo_data = data;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    localparam logic [127:0] D_A    = {32'h0000_0A03, 32'h0000_0A02, 32'h0000_0A01, 32'h0000_0A00};
    localparam logic [127:0] D_AA   = {32'h0000_0A03, 32'hAAAA_AAAA, 32'h0000_0A01, 32'h0000_0A00};
    localparam logic [127:0] D_BEEF = {32'h0, 32'hDEAD_BEEF, 64'h0};
    localparam logic [127:0] D_B    = {64'h0, 32'h0000_0B01, 32'h0000_0B00};

    initial begin
        vec_t tbl[15];
        int   hd[4];
        int   rec_w[$];
        logic [31:0] rec_d[$];
        logic [3:0] pop_seen;
        logic [3:0] pop_exp;
        int   underflow;
        int   stall_order[5];

        tbl[0]  = mk(1'b1, 1'b0, 4'b0100, 4'b0000, 1'b1, D_BEEF, 4'b0100, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'd2, 32'd0);
        tbl[1]  = mk(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, D_BEEF, 4'b0000, 1'b0, 1'b0, 32'hDEAD_BEEF, 2'd2, 32'd1);
        tbl[2]  = mk(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, D_BEEF, 4'b0000, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'd2, 32'd1);
        tbl[3]  = mk(1'b1, 1'b0, 4'b1111, 4'b0010, 1'b1, D_A,    4'b1000, 1'b0, 1'b1, 32'h0000_0A03, 2'd3, 32'd1);
        tbl[4]  = mk(1'b1, 1'b0, 4'b1111, 4'b0010, 1'b1, D_A,    4'b0001, 1'b0, 1'b1, 32'h0000_0A00, 2'd0, 32'd2);
        tbl[5]  = mk(1'b1, 1'b0, 4'b1111, 4'b0010, 1'b1, D_A,    4'b0100, 1'b0, 1'b1, 32'h0000_0A02, 2'd2, 32'd3);
        tbl[6]  = mk(1'b1, 1'b0, 4'b0010, 4'b0000, 1'b1, D_A,    4'b0010, 1'b0, 1'b1, 32'h0000_0A01, 2'd1, 32'd4);
        tbl[7]  = mk(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b1, D_A,    4'b0000, 1'b0, 1'b0, 32'h0000_0A01, 2'd1, 32'd5);
        tbl[8]  = mk(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b1, D_A,    4'b0000, 1'b0, 1'b0, 32'h0000_0A01, 2'd1, 32'd5);
        tbl[9]  = mk(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, D_AA,   4'b0100, 1'b0, 1'b1, 32'hAAAA_AAAA, 2'd2, 32'd5);
        tbl[10] = mk(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, D_AA,   4'b0000, 1'b0, 1'b1, 32'hAAAA_AAAA, 2'd2, 32'd5);
        tbl[11] = mk(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, D_AA,   4'b0000, 1'b0, 1'b0, 32'hAAAA_AAAA, 2'd2, 32'd5);
        tbl[12] = mk(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, D_A,    4'b1000, 1'b0, 1'b1, 32'h0000_0A03, 2'd3, 32'd5);
        tbl[13] = mk(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b1, D_A,    4'b0000, 1'b0, 1'b0, 32'h0000_0A03, 2'd3, 32'd6);
        tbl[14] = mk(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, D_A,    4'b0001, 1'b0, 1'b1, 32'h0000_0A00, 2'd0, 32'd6);

        // Reset state with eligible warps present: nothing may pop while rst_n is low.
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, D_A);
        #1;
        check("rst_pop", 32'(fifo_pop), 32'd0);
        check("rst_valid", 32'(issue_valid), 32'd0);
        check("rst_instr", issue_instr, 32'd0);
        check("rst_wid", 32'(issue_warp_id), 32'd0);
        check("rst_count", issue_count, 32'd0);
        reset_dut();

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].en, tbl[i].fl, tbl[i].fv, tbl[i].stall, tbl[i].rdy, tbl[i].data);
            #1;
            check($sformatf("vec%0d_pop", i), 32'(fifo_pop), 32'(tbl[i].pop));
            check($sformatf("vec%0d_idle", i), 32'(idle), 32'(tbl[i].idle_e));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), 32'(issue_valid), 32'(tbl[i].iv));
            check($sformatf("vec%0d_instr", i), issue_instr, tbl[i].instr);
            check($sformatf("vec%0d_wid", i), 32'(issue_warp_id), 32'(tbl[i].wid));
            check($sformatf("vec%0d_count", i), issue_count, tbl[i].cnt);
        end

        // Round-robin fairness: 4 FIFOs of 3 entries each, ready held high.
        reset_dut();
        hd = '{0, 0, 0, 0};
        underflow = 0;
        for (int c = 0; c < 16; c++) begin
            for (int w = 0; w < 4; w++) begin
                fifo_valid[w] = (hd[w] < 3);
                fifo_data[w*32 +: 32] = 32'h1000 + 32'(16 * w + hd[w]);
            end
            issue_ready = 1'b1;
            #1;
            pop_seen = fifo_pop;
            if ((pop_seen & ~fifo_valid) != 4'b0000) underflow++;
            @(posedge clk);
            #1;
            for (int w = 0; w < 4; w++) begin
                if (pop_seen[w]) hd[w]++;
            end
            if (issue_valid) begin
                rec_w.push_back(int'(issue_warp_id));
                rec_d.push_back(issue_instr);
            end
        end
        check("rr_issued", 32'(rec_w.size()), 32'd12);
        for (int k = 0; k < 12; k++) begin
            if (k < rec_w.size()) begin
                check($sformatf("rr_wid%0d", k), 32'(rec_w[k]), 32'(k % 4));
                check($sformatf("rr_data%0d", k), rec_d[k], 32'h1000 + 32'(16 * (k % 4) + k / 4));
            end
        end
        check("rr_count", issue_count, 32'd12);
        check("rr_idle", 32'(idle), 32'd1);
        check("rr_underflow", 32'(underflow), 32'd0);

        // Backpressure: warp 0 held for 5 cycles, then warp 1 follows without a bubble.
        reset_dut();
        drive(1'b1, 1'b0, 4'b0011, 4'b0000, 1'b0, D_B);
        #1;
        check("bp_pop0", 32'(fifo_pop), 32'b0001);
        @(posedge clk);
        #1;
        check("bp_wid0", 32'(issue_warp_id), 32'd0);
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0, D_B);
            #1;
            check($sformatf("bp_hold_pop%0d", c), 32'(fifo_pop), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_instr%0d", c), issue_instr, 32'h0000_0B00);
            check($sformatf("bp_hold_wid%0d", c), 32'(issue_warp_id), 32'd0);
        end
        drive(1'b1, 1'b0, 4'b0010, 4'b0000, 1'b1, D_B);
        #1;
        check("bp_rel_pop", 32'(fifo_pop), 32'b0010);
        @(posedge clk);
        #1;
        check("bp_rel_valid", 32'(issue_valid), 32'd1);
        check("bp_rel_instr", issue_instr, 32'h0000_0B01);
        check("bp_rel_wid", 32'(issue_warp_id), 32'd1);
        check("bp_rel_count", issue_count, 32'd1);

        // Stall skip: warp 1 stalled for four grants, then released.
        reset_dut();
        stall_order = '{0, 2, 3, 0, 1};
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b0, 4'b1111, (c < 4) ? 4'b0010 : 4'b0000, 1'b1, D_A);
            #1;
            pop_exp = 4'b0001;
            pop_exp = pop_exp << stall_order[c];
            check($sformatf("stall_pop%0d", c), 32'(fifo_pop), 32'(pop_exp));
            @(posedge clk);
            #1;
            check($sformatf("stall_wid%0d", c), 32'(issue_warp_id), 32'(stall_order[c]));
        end
        check("stall_count", issue_count, 32'd4);

        // Mid-burst asynchronous reset.
        drive(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, D_A);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(issue_valid), 32'd0);
        check("mrst_instr", issue_instr, 32'd0);
        check("mrst_wid", 32'(issue_warp_id), 32'd0);
        check("mrst_count", issue_count, 32'd0);
        check("mrst_pop", 32'(fifo_pop), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/warp_issue_scheduler.md
Name: warp_issue_scheduler

Overview:
- Round-robin issue scheduler sitting between NUM_WARPS per-warp instruction_fifo instances and the single execution-unit issue port.
- Each cycle it selects one eligible warp, which is a warp whose FIFO head is valid and is not stalled.
- It pops that warp's FIFO and registers the instruction into an output stage with a valid/ready handshake.
- It also keeps an accepted-issue counter for performance monitoring.

Parameters:
- NUM_WARPS, 4, number of warps / instruction FIFOs arbitrated (2..16).
- DATA_WIDTH, 32, instruction width; matches the instruction_fifo data width.
- WID_W, $clog2(NUM_WARPS), warp-id width (derived; do not override).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  when low, no new warp is granted; a held output still completes.
- flush  input  1  synchronous discard of the held output; blocks loads for that cycle.
- fifo_valid  input  NUM_WARPS  per-warp FIFO head valid (the FIFO's valid output).
- fifo_data  input  NUM_WARPS*DATA_WIDTH  per-warp FIFO head data; warp w occupies bits [w*DATA_WIDTH +: DATA_WIDTH].
- fifo_pop  output  NUM_WARPS  per-warp pop strobe; combinational, at most one bit set.
- warp_stall  input  NUM_WARPS  per-warp stall (barrier/scoreboard); a stalled warp is not eligible.
- issue_valid  output  1  issued instruction is present.
- issue_ready  input  1  execution unit accepts the instruction this cycle.
- issue_instr  output  DATA_WIDTH  issued instruction.
- issue_warp_id  output  WID_W  warp that owns issue_instr.
- issue_count  output  32  count of accepted issues; wraps at 2^32.
- idle  output  1  combinational: !issue_valid && fifo_valid == 0.

Behaviour:
- Reset (async, rst_n low) values:
  - issue_valid=0, issue_instr=0, issue_warp_id=0, issue_count=0.
  - rr_ptr=0, so warp 0 has highest priority first.
  - fifo_pop=0 during reset.
- Definitions:
  - eligible = fifo_valid & ~warp_stall.
  - accept = issue_valid && issue_ready.
  - load_en = enable && !flush && (!issue_valid || issue_ready).
- Grant:
  - When load_en is high and eligible is non-zero, grant = the first eligible index scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_WARPS.
  - fifo_pop[grant]=1 in the same cycle, combinationally from the current inputs.
  - Next edge: issue_instr <= fifo_data[grant], issue_warp_id <= grant, issue_valid <= 1, rr_ptr <= (grant+1) mod NUM_WARPS.
- Latency: a FIFO head present at cycle N appears on issue_* at cycle N+1.
- Back-to-back operation: with issue_ready held high, one issue per cycle is sustained.
- Drain: on accept with no new load, issue_valid <= 0 at the next edge.
- Hold: while issue_valid && !issue_ready, issue_instr and issue_warp_id are stable, fifo_pop=0 and rr_ptr is unchanged.
- warp_stall and enable affect selection only; they never retract a held output.
- Flush:
  - issue_valid <= 0 at the next edge; fifo_pop=0; rr_ptr preserved.
  - A handshake completing in the flush cycle is still counted; a held instruction not accepted is discarded and not counted.
- issue_count: +1 at each edge where accept is true; rolls over from 0xFFFFFFFF to 0.
- No eligible warp: no pop; issue_valid falls after accept; rr_ptr unchanged.
- Underflow: a pop is never issued for a warp whose fifo_valid=0.
- Mid-operation reset: everything returns to reset values immediately; no pop is asserted while rst_n is low.

Test Plan:
- Basic issue:
  - Stimulus: NUM_WARPS=4; warp 2 FIFO holds 0xDEADBEEF, others empty; issue_ready=1.
  - Required: fifo_pop=4'b0100 for one cycle; next cycle issue_valid=1, issue_instr=0xDEADBEEF, issue_warp_id=2; issue_count=1 after accept; idle=1 afterwards.
- Round-robin fairness:
  - Stimulus: all 4 FIFOs hold 3 entries (0x1000+16w+i); issue_ready=1.
  - Required: warp-id order 0,1,2,3,0,1,2,3,0,1,2,3; per-warp data in FIFO order; issue_count=12.
- Backpressure:
  - Stimulus: issue_ready=0 for 5 cycles with warps 0 and 1 loaded.
  - Required: issue_instr/issue_warp_id hold warp 0's head; fifo_pop=0 throughout.
  - Then: ready=1 -> warp 1 issues the next cycle with no bubble.
- Stall skip:
  - Stimulus: warp_stall=4'b0010, warps 0..3 valid.
  - Required: order 0,2,3,0; warp 1 issues only after its stall deasserts.
- Flush:
  - Stimulus: assert flush while the held instruction 0xAAAAAAAA has issue_ready=0.
  - Required: issue_valid=0 next cycle; issue_count unchanged; rr_ptr unchanged, so the next grant follows the flushed warp.
- Enable/reset:
  - Stimulus: enable=0 with valid FIFOs.
  - Required: no pops; idle=0; issue_valid=0.
  - Stimulus: assert rst_n=0 mid-burst.
  - Required: all outputs return to 0 immediately; issue_count=0.
